// File: rtl/softmax_seq.sv
// softmax_seq: collects two serial float logits, launches the 2-class softmax,
// captures the probabilities, picks the argmax and hands one result per frame
// to the host. Watches the softmax with a response timeout and counts frames.
module softmax_seq #(
  parameter int TIMEOUT = 15,  // response wait in cycles after launch, >= 5
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  // logit stream from the last FC layer
  input  logic             fc_valid,
  input  logic [31:0]      fc_data,
  output logic             fc_ready,
  // softmax datapath
  output logic             sm_valid_in,
  output logic [31:0]      sm_class0,
  output logic [31:0]      sm_class1,
  input  logic             sm_valid_out,
  input  logic [31:0]      sm_percent0,
  input  logic [31:0]      sm_percent1,
  // host result
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_class,
  output logic [31:0]      res_percent0,
  output logic [31:0]      res_percent1,
  // status
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_timeout,
  input  logic             clr_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT0,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic [TW-1:0]    tmo_q;
  logic             fc_ready_q;
  logic             sm_vin_q;
  logic [31:0]      c0_q, c1_q;
  logic             res_valid_q;
  logic             res_class_q;
  logic [31:0]      p0_q, p1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic accept;
  logic p1_wins;

  assign accept = fc_valid & fc_ready_q;
  // Probabilities are non-negative floats, so magnitude bits order them;
  // strict compare makes a tie resolve to class 0.
  assign p1_wins = sm_percent1[30:0] > sm_percent0[30:0];

  // Frame sequencer; every output comes straight from a register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      fc_ready_q  <= 1'b0;
      sm_vin_q    <= 1'b0;
      c0_q        <= '0;
      c1_q        <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= 1'b0;
      p0_q        <= '0;
      p1_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sm_vin_q <= 1'b0;
      // A timeout set later in this block overrides a same-cycle clear.
      if (clr_err) err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          fc_ready_q <= 1'b1;
          if (accept) begin
            c0_q    <= fc_data;
            state_q <= S_GOT0;
          end
        end
        S_GOT0: begin
          if (accept) begin
            c1_q       <= fc_data;
            fc_ready_q <= 1'b0;
            sm_vin_q   <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (sm_valid_out) begin
            p0_q        <= sm_percent0;
            p1_q        <= sm_percent1;
            res_class_q <= p1_wins;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else if (tmo_q == TMO_LAST) begin
            err_q      <= 1'b1;
            fc_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            fc_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          fc_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign fc_ready     = fc_ready_q;
  assign sm_valid_in  = sm_vin_q;
  assign sm_class0    = c0_q;
  assign sm_class1    = c1_q;
  assign res_valid    = res_valid_q;
  assign res_class    = res_class_q;
  assign res_percent0 = p0_q;
  assign res_percent1 = p1_q;
  assign frame_cnt    = cnt_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq with a 4-cycle softmax stub and a result
// scoreboard; CNT_W=2 so the frame counter wrap is exercised.
module tb_softmax_seq;

  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 2;

  logic             clk;
  logic             resetn;
  logic             fc_valid;
  logic [31:0]      fc_data;
  logic             fc_ready;
  logic             sm_valid_in;
  logic [31:0]      sm_class0, sm_class1;
  logic             sm_valid_out;
  logic [31:0]      sm_percent0, sm_percent1;
  logic             res_valid;
  logic             res_ready;
  logic             res_class;
  logic [31:0]      res_percent0, res_percent1;
  logic [CNT_W-1:0] frame_cnt;
  logic             err_timeout;
  logic             clr_err;

  softmax_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .fc_valid(fc_valid), .fc_data(fc_data), .fc_ready(fc_ready),
    .sm_valid_in(sm_valid_in), .sm_class0(sm_class0), .sm_class1(sm_class1),
    .sm_valid_out(sm_valid_out), .sm_percent0(sm_percent0), .sm_percent1(sm_percent1),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_percent0(res_percent0), .res_percent1(res_percent1),
    .frame_cnt(frame_cnt), .err_timeout(err_timeout), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Softmax stub: fixed probability table, 4-cycle latency, not reset.
  function automatic void sm_lut(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] p0, output logic [31:0] p1);
    case ({a, b})
      {32'h3F800000, 32'h00000000}: begin p0 = 32'h3F3B26A8; p1 = 32'h3E89B2AE; end
      {32'h40000000, 32'h40000000}: begin p0 = 32'h3F000000; p1 = 32'h3F000000; end
      {32'h00000000, 32'h40000000}: begin p0 = 32'h3DF4279A; p1 = 32'h3F6176A7; end
      {32'h3F000000, 32'h3F000001}: begin p0 = 32'h3EFFFFFF; p1 = 32'h3F000001; end
      default:                      begin p0 = 32'h3F000000; p1 = 32'h3F000000; end
    endcase
  endfunction

  logic       silent = 1'b0;
  logic       spur   = 1'b0;
  logic [3:0] sm_pipe = '0;
  logic [31:0] lp0, lp1;

  always @(posedge clk) begin
    sm_pipe <= {sm_pipe[2:0], sm_valid_in & ~silent};
    if (sm_valid_in) begin
      sm_lut(sm_class0, sm_class1, lp0, lp1);
      sm_percent0 <= lp0;
      sm_percent1 <= lp1;
    end
  end
  assign sm_valid_out = sm_pipe[3] | spur;

  // Scoreboard of expected results.
  typedef struct packed {
    logic [31:0] p0;
    logic [31:0] p1;
    logic        cls;
  } exp_t;
  exp_t sb[$];

  logic [CNT_W-1:0] exp_cnt = '0;
  logic             expect_res = 1'b0;

  // Any result outside an expected window is an error.
  always @(negedge clk) begin
    if (resetn === 1'b1 && !expect_res) begin
      n_assert++;
      assert (res_valid === 1'b0) else begin
        n_fail++;
        $error("FAIL unexpected_res_valid: observed %b expected 0", res_valid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat; returns one cycle after it is accepted.
  task automatic send_beat(input logic [31:0] d);
    int n;
    fc_valid = 1'b1;
    fc_data  = d;
    n = 0;
    while (fc_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("fc_ready_wait", {31'b0, fc_ready}, 32'd1);
    step();
    fc_valid = 1'b0;
  endtask

  // Full frame with result check; bp = cycles the host withholds res_ready.
  task automatic do_frame(input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] p0, input logic [31:0] p1,
                          input logic cls, input int bp);
    exp_t e;
    logic [31:0] junk;
    sb.push_back('{p0: p0, p1: p1, cls: cls});
    res_ready = (bp == 0);
    send_beat(c0);
    send_beat(c1);                               // cycle a+1
    expect_res = 1'b1;
    chk("launch_pulse", {31'b0, sm_valid_in}, 32'd1);
    chk("launch_class0", sm_class0, c0);
    chk("launch_class1", sm_class1, c1);
    chk("launch_fc_ready", {31'b0, fc_ready}, 32'd0);
    step();                                      // a+2
    chk("launch_width", {31'b0, sm_valid_in}, 32'd0);
    step(); step(); step();                      // a+5
    chk("res_valid_early", {31'b0, res_valid}, 32'd0);
    step();                                      // a+6
    chk("res_valid_latency", {31'b0, res_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("res_class", {31'b0, res_class}, {31'b0, e.cls});
      chk("res_percent0", res_percent0, e.p0);
      chk("res_percent1", res_percent1, e.p1);
    end
    for (int i = 0; i < bp; i++) begin
      junk = $urandom;
      fc_valid = 1'b1;
      fc_data  = junk;
      step();
      chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_res_class", {31'b0, res_class}, {31'b0, e.cls});
      chk("bp_res_percent0", res_percent0, e.p0);
      chk("bp_res_percent1", res_percent1, e.p1);
      chk("bp_fc_ready", {31'b0, fc_ready}, 32'd0);
      chk("bp_frame_cnt", {30'b0, frame_cnt}, {30'b0, exp_cnt});
    end
    fc_valid  = 1'b0;
    res_ready = 1'b1;
    exp_cnt   = exp_cnt + 1'b1;
    step();                                      // first IDLE cycle
    chk("frame_cnt", {30'b0, frame_cnt}, {30'b0, exp_cnt});
    chk("res_valid_drop", {31'b0, res_valid}, 32'd0);
    chk("fc_ready_after", {31'b0, fc_ready}, 32'd1);
    expect_res = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fc_ready"}, {31'b0, fc_ready}, 32'd0);
    chk({tag, "_sm_valid_in"}, {31'b0, sm_valid_in}, 32'd0);
    chk({tag, "_sm_class0"}, sm_class0, 32'd0);
    chk({tag, "_sm_class1"}, sm_class1, 32'd0);
    chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    chk({tag, "_res_class"}, {31'b0, res_class}, 32'd0);
    chk({tag, "_res_percent0"}, res_percent0, 32'd0);
    chk({tag, "_res_percent1"}, res_percent1, 32'd0);
    chk({tag, "_frame_cnt"}, {30'b0, frame_cnt}, 32'd0);
    chk({tag, "_err_timeout"}, {31'b0, err_timeout}, 32'd0);
  endtask

  initial begin
    resetn    = 1'b1;
    fc_valid  = 1'b0;
    fc_data   = '0;
    res_ready = 1'b1;
    clr_err   = 1'b0;

    // Power-on reset
    #3 resetn = 1'b0;
    #1 chk_all_zero("reset");
    step(); step();
    resetn = 1'b1;
    chk("fc_ready_in_release", {31'b0, fc_ready}, 32'd0);
    step();
    chk("fc_ready_after_release", {31'b0, fc_ready}, 32'd1);

    // Normal, tie, class-1 win, one-LSB-ish class-1 win
    do_frame(32'h3F800000, 32'h00000000, 32'h3F3B26A8, 32'h3E89B2AE, 1'b0, 0);  // cnt 1
    do_frame(32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000, 1'b0, 0);  // cnt 2
    do_frame(32'h00000000, 32'h40000000, 32'h3DF4279A, 32'h3F6176A7, 1'b1, 0);  // cnt 3

    // Backpressure for 10 cycles with logits pending on fc
    do_frame(32'h00000000, 32'h40000000, 32'h3DF4279A, 32'h3F6176A7, 1'b1, 10); // cnt 0

    // Timeout with a silent softmax; L is the launch cycle
    silent = 1'b1;
    send_beat(32'h3F800000);
    send_beat(32'h00000000);                     // cycle L
    chk("tmo_launch", {31'b0, sm_valid_in}, 32'd1);
    for (int i = 0; i < TIMEOUT; i++) step();    // L+15
    chk("tmo_err_early", {31'b0, err_timeout}, 32'd0);
    chk("tmo_fc_ready_wait", {31'b0, fc_ready}, 32'd0);
    step();                                      // L+16
    chk("tmo_err_set", {31'b0, err_timeout}, 32'd1);
    chk("tmo_idle_fc_ready", {31'b0, fc_ready}, 32'd1);
    chk("tmo_frame_cnt", {30'b0, frame_cnt}, {30'b0, exp_cnt});
    silent = 1'b0;
    spur   = 1'b1;
    step();
    spur   = 1'b0;
    step(); step();
    chk("spur_res_valid", {31'b0, res_valid}, 32'd0);
    chk("spur_err_sticky", {31'b0, err_timeout}, 32'd1);
    chk("spur_frame_cnt", {30'b0, frame_cnt}, {30'b0, exp_cnt});
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", {31'b0, err_timeout}, 32'd0);

    // Reset two cycles after launch; the in-flight softmax pulse must be dropped
    send_beat(32'h40000000);
    send_beat(32'h40000000);                     // cycle L
    step(); step();                              // L+2
    resetn = 1'b0;
    #1 chk_all_zero("midreset");
    step();                                      // L+3
    resetn  = 1'b1;
    exp_cnt = '0;
    step();                                      // L+4, stray pulse arrives
    step(); step(); step();
    chk("midreset_no_result", {31'b0, res_valid}, 32'd0);
    chk("midreset_fc_ready", {31'b0, fc_ready}, 32'd1);
    chk("midreset_frame_cnt", {30'b0, frame_cnt}, 32'd0);

    // Five frames from zero: counter 1, 2, 3, 0, 1
    do_frame(32'h3F800000, 32'h00000000, 32'h3F3B26A8, 32'h3E89B2AE, 1'b0, 0);
    do_frame(32'h3F000000, 32'h3F000001, 32'h3EFFFFFF, 32'h3F000001, 1'b1, 0);
    do_frame(32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000, 1'b0, 0);
    do_frame(32'h00000000, 32'h40000000, 32'h3DF4279A, 32'h3F6176A7, 1'b1, 0);
    do_frame(32'h3F800000, 32'h00000000, 32'h3F3B26A8, 32'h3E89B2AE, 1'b0, 0);
    chk("wrap_final_cnt", {30'b0, frame_cnt}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
